// File: rtl/morse_pkg.sv
// Shared command codes, pending-bit indices and scheduler state encoding
// for the Morse key front-end.
package morse_pkg;

    localparam logic [2:0] CMD_NONE  = 3'd0;
    localparam logic [2:0] CMD_SHORT = 3'd1;
    localparam logic [2:0] CMD_LONG  = 3'd2;
    localparam logic [2:0] CMD_SEND  = 3'd3;
    localparam logic [2:0] CMD_BACK  = 3'd4;
    localparam logic [2:0] CMD_CLEAR = 3'd5;

    localparam int PEND_SHORT = 0;
    localparam int PEND_LONG  = 1;
    localparam int PEND_SEND  = 2;
    localparam int PEND_BACK  = 3;
    localparam int PEND_CLEAR = 4;
    localparam int NUM_KEYS   = 5;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } sched_state_t;

    // Fixed priority: CLEAR > BACK > SEND > LONG > SHORT.
    function automatic logic [2:0] pend_to_code(input logic [NUM_KEYS-1:0] pend);
        logic [2:0] code;
        code = CMD_NONE;
        if (pend[PEND_CLEAR])      code = CMD_CLEAR;
        else if (pend[PEND_BACK])  code = CMD_BACK;
        else if (pend[PEND_SEND])  code = CMD_SEND;
        else if (pend[PEND_LONG])  code = CMD_LONG;
        else if (pend[PEND_SHORT]) code = CMD_SHORT;
        return code;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Single-button debouncer: the level follows raw only after raw has differed
// from it for DB_CYCLES consecutive cycles; press_pulse marks each 0->1 change.
module key_debounce #(
    parameter int DB_CYCLES = 2_000_000
) (
    input  logic clk,
    input  logic enable,
    input  logic raw,
    output logic level,
    output logic press_pulse
);

    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(DB_CYCLES - 1);

    logic [CW-1:0] cnt;

    // Down-counter reloads while raw agrees with level; terminal count flips level.
    always_ff @(posedge clk or negedge enable) begin
        if (!enable) begin
            cnt         <= RELOAD;
            level       <= 1'b0;
            press_pulse <= 1'b0;
        end else begin
            press_pulse <= 1'b0;
            if (raw == level) begin
                cnt <= RELOAD;
            end else if (cnt == '0) begin
                cnt         <= RELOAD;
                level       <= raw;
                press_pulse <= raw;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/morse_key_sched.sv
// Morse key scheduler: debounced presses become pending requests issued one at
// a time by priority. Optional idle auto-SEND is enabled with macro AUTO_SEND_EN.
//
// state | meaning
// IDLE  | no command offered; latch highest-priority pending code if any
// ISSUE | cmd_valid high with latched code until the decoder accepts it
module morse_key_sched
    import morse_pkg::*;
#(
    parameter int DB_CYCLES        = 2_000_000,
    parameter int AUTO_SEND_CYCLES = 100_000_000,
    parameter int MAX_SYMBOLS      = 5
) (
    input  logic       clk,
    input  logic       enable,
    input  logic       short_key,
    input  logic       long_key,
    input  logic       send,
    input  logic       back_space,
    input  logic       reset,
    input  logic       cmd_ready,
    output logic       cmd_valid,
    output logic [2:0] cmd_code,
    output logic [2:0] sym_cnt,
    output logic [7:0] drop_cnt
);

    logic [NUM_KEYS-1:0] raw_keys;
    logic [NUM_KEYS-1:0] levels;
    logic [NUM_KEYS-1:0] pulses;
    logic [NUM_KEYS-1:0] press;

    assign raw_keys = {reset, back_space, send, long_key, short_key};

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_db
        key_debounce #(
            .DB_CYCLES(DB_CYCLES)
        ) u_db (
            .clk        (clk),
            .enable     (enable),
            .raw        (raw_keys[k]),
            .level      (levels[k]),
            .press_pulse(pulses[k])
        );
    end

    assign press = pulses & levels;

    sched_state_t        state, state_nxt;
    logic [2:0]          code_q, code_nxt;
    logic [NUM_KEYS-1:0] pend, pend_nxt;
    logic [NUM_KEYS-1:0] grant_clr;
    logic [NUM_KEYS-1:0] auto_set;
    logic [NUM_KEYS-1:0] drops;
    logic [2:0]          sym_nxt;
    logic [8:0]          drop_sum;
    logic [7:0]          drop_nxt;
    logic                handshake;
    logic                auto_fire;

    always_comb begin
        state_nxt = state;
        code_nxt  = code_q;
        cmd_valid = 1'b0;
        cmd_code  = CMD_NONE;
        case (state)
            IDLE: begin
                if (|pend) begin
                    code_nxt  = pend_to_code(pend);
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                cmd_valid = 1'b1;
                cmd_code  = code_q;
                if (cmd_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign handshake = cmd_valid & cmd_ready;

    always_comb begin
        grant_clr = '0;
        sym_nxt   = sym_cnt;
        if (handshake) begin
            case (code_q)
                CMD_SHORT: begin
                    grant_clr[PEND_SHORT] = 1'b1;
                    if (sym_cnt < 3'(MAX_SYMBOLS)) sym_nxt = sym_cnt + 3'd1;
                end
                CMD_LONG: begin
                    grant_clr[PEND_LONG] = 1'b1;
                    if (sym_cnt < 3'(MAX_SYMBOLS)) sym_nxt = sym_cnt + 3'd1;
                end
                CMD_SEND: begin
                    grant_clr[PEND_SEND] = 1'b1;
                    sym_nxt = '0;
                end
                CMD_BACK: begin
                    grant_clr[PEND_BACK] = 1'b1;
                    if (sym_cnt != 3'd0) sym_nxt = sym_cnt - 3'd1;
                end
                CMD_CLEAR: begin
                    grant_clr = '1;
                    sym_nxt   = '0;
                end
                default: ;
            endcase
        end
    end

    // A press racing its own grant re-arms the bit instead of counting as a drop.
    always_comb begin
        auto_set            = '0;
        auto_set[PEND_SEND] = auto_fire;
    end

    assign drops    = press & pend & ~grant_clr;
    assign pend_nxt = (pend & ~grant_clr) | press | auto_set;
    assign drop_sum = 9'(drop_cnt) + 9'($countones(drops));
    assign drop_nxt = drop_sum[8] ? 8'hFF : drop_sum[7:0];

    always_ff @(posedge clk or negedge enable) begin
        if (!enable) begin
            state    <= IDLE;
            code_q   <= CMD_NONE;
            pend     <= '0;
            sym_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            state    <= state_nxt;
            code_q   <= code_nxt;
            pend     <= pend_nxt;
            sym_cnt  <= sym_nxt;
            drop_cnt <= drop_nxt;
        end
    end

`ifdef AUTO_SEND_EN
    localparam int AW = (AUTO_SEND_CYCLES > 1) ? $clog2(AUTO_SEND_CYCLES) : 1;
    localparam logic [AW-1:0] AUTO_RELOAD = AW'(AUTO_SEND_CYCLES - 1);

    logic [AW-1:0] idle_cnt;
    logic          idle_run;

    assign idle_run  = (state == IDLE) && (pend == '0) && (sym_cnt != 3'd0) &&
                       !handshake && (press == '0);
    assign auto_fire = idle_run && (idle_cnt == '0);

    always_ff @(posedge clk or negedge enable) begin
        if (!enable) begin
            idle_cnt <= AUTO_RELOAD;
        end else if (!idle_run || auto_fire) begin
            idle_cnt <= AUTO_RELOAD;
        end else begin
            idle_cnt <= idle_cnt - 1'b1;
        end
    end
`else
    // Parameter kept so both builds share one interface; this never fires.
    assign auto_fire = (AUTO_SEND_CYCLES < 0);
`endif

endmodule

// File: tb/tb_morse_key_sched.sv
// Directed bench for morse_key_sched with short debounce and auto-send timers.
module tb_morse_key_sched;

    logic       clk = 1'b0;
    logic       enable;
    logic [4:0] keys;
    logic       cmd_ready;
    logic       cmd_valid;
    logic [2:0] cmd_code;
    logic [2:0] sym_cnt;
    logic [7:0] drop_cnt;

    int n_vec = 0;
    int n_err = 0;
    logic [2:0] hs_log[$];

    always #5 clk = ~clk;

    morse_key_sched #(
        .DB_CYCLES       (4),
        .AUTO_SEND_CYCLES(50),
        .MAX_SYMBOLS     (5)
    ) dut (
        .clk       (clk),
        .enable    (enable),
        .short_key (keys[0]),
        .long_key  (keys[1]),
        .send      (keys[2]),
        .back_space(keys[3]),
        .reset     (keys[4]),
        .cmd_ready (cmd_ready),
        .cmd_valid (cmd_valid),
        .cmd_code  (cmd_code),
        .sym_cnt   (sym_cnt),
        .drop_cnt  (drop_cnt)
    );

    always @(posedge clk) begin
        if (cmd_valid && cmd_ready) hs_log.push_back(cmd_code);
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Long enough for debounce, issue and handshake, then full release.
    task automatic press_key(input int idx);
        keys[idx] = 1'b1;
        step(6);
        keys[idx] = 1'b0;
        step(8);
    endtask

    initial begin
        int n_ok;

        enable    = 1'b0;
        keys      = '0;
        cmd_ready = 1'b1;
        step(2);
        chk("rst_valid", 8'(cmd_valid), 8'd0);
        chk("rst_code",  8'(cmd_code),  8'd0);
        chk("rst_sym",   8'(sym_cnt),   8'd0);
        chk("rst_drop",  drop_cnt,      8'd0);
        enable = 1'b1;
        step(2);

        // Bounce of three cycles never reaches the debounced level.
        keys[0] = 1'b1;
        step(3);
        keys[0] = 1'b0;
        step(10);
        chk("bounce_cmds",  8'(hs_log.size()), 8'd0);
        chk("bounce_valid", 8'(cmd_valid),     8'd0);

        // Held press: level at edge 4, pend at 5, valid after edge 6, handshake at 7.
        keys[0] = 1'b1;
        step(5);
        chk("lat_valid_lo", 8'(cmd_valid), 8'd0);
        step(1);
        chk("lat_valid_hi", 8'(cmd_valid), 8'd1);
        chk("lat_code",     8'(cmd_code),  8'd1);
        chk("lat_sym_pre",  8'(sym_cnt),   8'd0);
        step(1);
        chk("lat_sym_post", 8'(sym_cnt),   8'd1);
        chk("lat_valid_dn", 8'(cmd_valid), 8'd0);
        step(3);
        keys[0] = 1'b0;
        step(10);
        chk("short_count", 8'(hs_log.size()), 8'd1);
        chk("short_code",  8'(hs_log[0]),     8'd1);

        // CLEAR granted first flushes the simultaneous LONG and SHORT.
        hs_log.delete();
        keys = 5'b10011;
        step(6);
        keys = '0;
        step(15);
        chk("clr_count", 8'(hs_log.size()), 8'd1);
        chk("clr_code",  8'(hs_log[0]),     8'd5);
        chk("clr_sym",   8'(sym_cnt),       8'd0);
        chk("clr_drop",  drop_cnt,          8'd0);

        // LONG before SHORT when pressed together.
        hs_log.delete();
        keys = 5'b00011;
        step(6);
        keys = '0;
        step(15);
        chk("ls_count", 8'(hs_log.size()), 8'd2);
        chk("ls_first", 8'(hs_log[0]),     8'd2);
        chk("ls_second",8'(hs_log[1]),     8'd1);
        chk("ls_sym",   8'(sym_cnt),       8'd2);

        // BACK before SEND when pressed together.
        hs_log.delete();
        keys = 5'b01100;
        step(6);
        keys = '0;
        step(15);
        chk("bs_count", 8'(hs_log.size()), 8'd2);
        chk("bs_first", 8'(hs_log[0]),     8'd4);
        chk("bs_second",8'(hs_log[1]),     8'd3);
        chk("bs_sym",   8'(sym_cnt),       8'd0);

        // Back-pressure: LONG held on the port, second press merges as a drop.
        hs_log.delete();
        cmd_ready = 1'b0;
        keys[1]   = 1'b1;
        step(6);
        keys[1]   = 1'b0;
        n_ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 6)  keys[1] = 1'b1;
            if (i == 12) keys[1] = 1'b0;
            if (cmd_valid === 1'b1 && cmd_code === 3'd2) n_ok++;
            step(1);
        end
        chk("bp_stable", 8'(n_ok),           8'd20);
        chk("bp_drop",   drop_cnt,           8'd1);
        chk("bp_nohs",   8'(hs_log.size()),  8'd0);
        cmd_ready = 1'b1;
        step(10);
        chk("bp_count",  8'(hs_log.size()),  8'd1);
        chk("bp_code",   8'(hs_log[0]),      8'd2);
        chk("bp_sym",    8'(sym_cnt),        8'd1);

        // Seven shorts saturate at five symbols.
        hs_log.delete();
        for (int i = 0; i < 7; i++) press_key(0);
        n_ok = 0;
        foreach (hs_log[i]) if (hs_log[i] == 3'd1) n_ok++;
        chk("sat_count", 8'(hs_log.size()), 8'd7);
        chk("sat_codes", 8'(n_ok),          8'd7);
        chk("sat_sym",   8'(sym_cnt),       8'd5);

        // Six backspaces stop at zero.
        hs_log.delete();
        press_key(3);
        chk("back_first", 8'(sym_cnt), 8'd4);
        for (int i = 0; i < 5; i++) press_key(3);
        n_ok = 0;
        foreach (hs_log[i]) if (hs_log[i] == 3'd4) n_ok++;
        chk("back_count", 8'(hs_log.size()), 8'd6);
        chk("back_codes", 8'(n_ok),          8'd6);
        chk("back_sym",   8'(sym_cnt),       8'd0);

        // Reset while a command is offered.
        press_key(0);
        chk("pre_rst_sym", 8'(sym_cnt), 8'd1);
        cmd_ready = 1'b0;
        keys[1]   = 1'b1;
        step(6);
        chk("pre_rst_valid", 8'(cmd_valid), 8'd1);
        enable = 1'b0;
        step(1);
        chk("en_valid", 8'(cmd_valid), 8'd0);
        chk("en_code",  8'(cmd_code),  8'd0);
        chk("en_sym",   8'(sym_cnt),   8'd0);
        chk("en_drop",  drop_cnt,      8'd0);
        keys = '0;
        step(2);
        hs_log.delete();
        enable    = 1'b1;
        cmd_ready = 1'b1;
        step(20);
        chk("en_nocmd",   8'(hs_log.size()), 8'd0);
        chk("en_noval",   8'(cmd_valid),     8'd0);

        // Idle after one symbol.
        hs_log.delete();
        press_key(0);
`ifdef AUTO_SEND_EN
        for (int i = 0; i < 80 && hs_log.size() < 2; i++) step(1);
        step(2);
        chk("auto_count", 8'(hs_log.size()), 8'd2);
        chk("auto_code",  8'(hs_log[1]),     8'd3);
        chk("auto_sym",   8'(sym_cnt),       8'd0);
`else
        step(80);
        chk("noauto_count", 8'(hs_log.size()), 8'd1);
        chk("noauto_sym",   8'(sym_cnt),       8'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
